// File: rtl/timer_share_arbiter.sv
// Round-robin share of one n-bit delay counter; grant one edge after request, done V cycles later.
// Requests arriving while the counter is owned simply wait; an owner dropping req aborts its delay.
module timer_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int n     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*n-1:0] delay_value,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic [n-1:0]       count
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [IW-1:0]    r_idx, w_idx_nxt;
  logic [IW-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [n-1:0]     r_delay, w_delay_nxt;
  logic [n-1:0]     r_count, w_count_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic [N_REQ-1:0] w_done;
  logic [IW-1:0]    w_cand;
  logic [IW-1:0]    w_pick;
  logic             w_found;
  logic             w_expired;

  // First requester at or after the round-robin pointer, wrapping modulo N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = IW'((int'(r_rr_ptr) + k) % N_REQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_expired = (r_count == r_delay);

  always_comb begin
    w_done = '0;
    if (r_state == RUN && w_expired) begin
      w_done = r_grant;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_rr_ptr_nxt = r_rr_ptr;
    w_delay_nxt  = r_delay;
    w_count_nxt  = r_count;
    w_grant_nxt  = r_grant;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt          = RUN;
          w_idx_nxt            = w_pick;
          w_delay_nxt          = delay_value[int'(w_pick)*n +: n];
          w_count_nxt          = '0;
          w_grant_nxt          = '0;
          w_grant_nxt[w_pick]  = 1'b1;
          w_rr_ptr_nxt         = IW'((int'(w_pick) + 1) % N_REQ);
        end
      end
      RUN: begin
        // Completion wins over a simultaneous req drop: both release identically.
        if (w_expired || !req[r_idx]) begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
          w_grant_nxt = '0;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_rr_ptr <= '0;
      r_delay  <= '0;
      r_count  <= '0;
      r_grant  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_delay  <= w_delay_nxt;
      r_count  <= w_count_nxt;
      r_grant  <= w_grant_nxt;
    end
  end

  assign grant = r_grant;
  assign done  = w_done;
  assign busy  = (r_state == RUN);
  assign count = r_count;

endmodule

// File: tb/tb_timer_share_arbiter.sv
// Bench for timer_share_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_timer_share_arbiter;

  localparam int NR = 4;
  localparam int NB = 16;

  logic             clk;
  logic             reset_n;
  logic [NR-1:0]    req;
  logic [NR*NB-1:0] delay_value;
  logic [NR-1:0]    grant, done;
  logic             busy;
  logic [NB-1:0]    count;

  logic [1:0]       req8;
  logic [15:0]      dv8;
  logic [1:0]       grant8, done8;
  logic             busy8;
  logic [7:0]       count8;

  int n_tests = 0;
  int n_fail  = 0;

  timer_share_arbiter #(.N_REQ(NR), .n(NB)) u_dut (
    .clk(clk), .reset_n(reset_n), .req(req), .delay_value(delay_value),
    .grant(grant), .done(done), .busy(busy), .count(count)
  );

  timer_share_arbiter #(.N_REQ(2), .n(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .req(req8), .delay_value(dv8),
    .grant(grant8), .done(done8), .busy(busy8), .count(count8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: owner index (-1 when free), cycles elapsed since grant, latched delay, next rr start.
  int m_owner = -1;
  int m_el    = 0;
  int m_v     = 0;
  int m_next  = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner = -1;
      m_el    = 0;
      m_v     = 0;
      m_next  = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < NR; k++) begin
        if (m_owner < 0 && req[(m_next + k) % NR]) m_owner = (m_next + k) % NR;
      end
      if (m_owner >= 0) begin
        m_v    = int'(delay_value[m_owner*NB +: NB]);
        m_el   = 0;
        m_next = (m_owner + 1) % NR;
      end
    end else if (m_el == m_v || !req[m_owner]) begin
      m_owner = -1;
      m_el    = 0;
    end else begin
      m_el++;
    end
  end

  always @(negedge clk) begin
    int eg, ed;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    ed = (m_owner >= 0 && m_el == m_v) ? eg : 0;
    chk("cmp_grant", grant, eg);
    chk("cmp_done",  done,  ed);
    chk("cmp_busy",  busy,  (m_owner >= 0) ? 1 : 0);
    chk("cmp_count", count, (m_owner >= 0) ? m_el : 0);
  end

  initial begin
    bit got, wrapped;
    int prev;
    reset_n = 1'b1;
    req = '0;
    delay_value = '0;
    req8 = '0;
    dv8 = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_done",  done,  0);
    chk("rst_busy",  busy,  0);
    chk("rst_count", count, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single request, delay 5
    delay_value[0*NB +: NB] = 16'd5;
    req = 4'b0001;
    tick();
    chk("t1_grant", grant, 4'b0001);
    chk("t1_busy",  busy,  1);
    repeat (5) tick();
    chk("t1_count", count, 5);
    chk("t1_done",  done,  4'b0001);
    req = '0;
    tick();
    chk("t1_release", grant, 0);

    // Zero delay
    delay_value[2*NB +: NB] = 16'd0;
    req = 4'b0100;
    tick();
    chk("t2_grant", grant, 4'b0100);
    chk("t2_done",  done,  4'b0100);
    req = '0;
    tick();
    chk("t2_release", grant, 0);

    // Fairness from a fresh pointer
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < NR; i++) delay_value[i*NB +: NB] = 16'd2;
    req = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      tick();
      chk("t3_grant", grant, 1 << (g % 4));
      repeat (2) tick();
      chk("t3_done", done, 1 << (g % 4));
      tick();
      chk("t3_idle", busy, 0);
    end
    req = '0;
    tick();

    // Abort with a waiting requester
    delay_value[1*NB +: NB] = 16'd10;
    delay_value[3*NB +: NB] = 16'd1;
    req = 4'b0010;
    tick();
    chk("t4_grant", grant, 4'b0010);
    req = 4'b1010;
    repeat (3) tick();
    chk("t4_count", count, 3);
    req = 4'b1000;
    tick();
    chk("t4_abort_grant", grant, 0);
    chk("t4_abort_count", count, 0);
    tick();
    chk("t4_next_grant", grant, 4'b1000);
    req = '0;
    repeat (2) tick();

    // Reset between edges mid-run
    delay_value[2*NB +: NB] = 16'd8;
    req = 4'b0100;
    tick();
    repeat (4) tick();
    chk("t5_count", count, 4);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_grant", grant, 0);
    chk("t5_done",  done,  0);
    chk("t5_busy",  busy,  0);
    chk("t5_cnt0",  count, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    delay_value[0*NB +: NB] = 16'd3;
    delay_value[3*NB +: NB] = 16'd3;
    req = 4'b1001;
    tick();
    chk("t5_rr_restart", grant, 4'b0001);
    req = '0;
    repeat (3) tick();

    // Random traffic, compare process checks every cycle
    repeat (1500) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        int r;
        r = $urandom_range(0, 15);
        if (done[i] && r < 10) req[i] = 1'b0;
        else if (!req[i] && r < 4) req[i] = 1'b1;
        else if (req[i] && r == 15) req[i] = 1'b0;
        if ($urandom_range(0, 3) == 0) delay_value[i*NB +: NB] = NB'($urandom_range(0, 6));
      end
    end
    req = '0;
    repeat (10) tick();

    // n=8 boundary: full-scale delay with no wrap
    dv8[7:0] = 8'd255;
    req8 = 2'b01;
    tick();
    chk("t6_grant", grant8, 2'b01);
    got = 0; wrapped = 0; prev = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      if (done8[0]) got = 1;
      else begin
        tick();
        if (int'(count8) < prev) wrapped = 1;
        prev = int'(count8);
      end
    end
    chk("t6_done_seen", got, 1);
    chk("t6_count255", count8, 255);
    chk("t6_no_wrap", wrapped, 0);
    req8 = '0;
    tick();
    chk("t6_release", grant8, 0);
    chk("t6_cnt0", count8, 0);

    // Delay change after grant is ignored
    dv8[7:0] = 8'd5;
    req8 = 2'b01;
    tick();
    dv8[7:0] = 8'd2;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      if (done8[0]) got = 1;
      else tick();
    end
    chk("t6b_done_seen", got, 1);
    chk("t6b_count", count8, 5);
    req8 = '0;
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_share_arbiter.md
Name: timer_share_arbiter

Overview:
- Shares one n-bit delay counter among N_REQ requesters, granting them round-robin.
- Each requester asks for a one-shot delay of its own programmed length and receives a one-cycle done pulse when that delay expires.
- Sits between control FSMs that need timed waits and the single timing resource, so each client does not need its own timer.

Parameters:
N_REQ, 4, number of requesters (>=2).
n, 16, counter and delay width in bits.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
req  input  N_REQ  level request per requester; held high until done or abort.
delay_value  input  N_REQ*n  packed delays; slot i occupies bits [i*n +: n].
grant  output  N_REQ  one-hot current owner of the counter; all-zero when idle.
done  output  N_REQ  one-cycle completion pulse to the owner.
busy  output  1  high while the counter is owned.
count  output  n  current counter value (debug/observability).

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - Reset forces state IDLE, grant=0, done=0, busy=0, count=0, rr_ptr=0 and latched delay=0, immediately and regardless of clk.
  - Reset mid-RUN aborts the delay with no done.
- States: IDLE, RUN.
- IDLE:
  - If req is all-zero, stay in IDLE.
  - Otherwise, at the edge, select the first set req bit searching rr_ptr, rr_ptr+1, ... modulo N_REQ.
  - At that edge: latch the index, latch delay_value slot, count<=0, grant<=onehot(index), busy<=1, rr_ptr<=(index+1) mod N_REQ, go RUN.
- RUN:
  - count increments by 1 at each edge while in RUN.
  - done[index] is high during the cycle in which count == latched delay. It is decoded only from registered state, count and latched delay, with no combinational path from inputs.
  - The edge after the done cycle goes to IDLE, with grant=0 and busy=0.
  - Latency: grant edge k gives done in the cycle after edge k+V and release at edge k+V+1, for V the latched delay.
  - V=0 asserts done in the first granted cycle.
- Minimum gap: at least one IDLE cycle between consecutive grants. A requester still holding req after done is re-arbitrated normally; round-robin order guarantees other pending requesters go first.
- Abort:
  - If req[index] is sampled low at an edge in RUN while count != latched delay, go IDLE at that edge: grant=0, busy=0, count=0, no done.
  - If req drops during the done cycle, the completion stands; the release is identical to normal completion.
- delay_value is sampled only at the grant edge. Changes during RUN are ignored, as are changes to non-granted slots.
- Requests arriving during RUN wait; no preemption.
- count never wraps: the maximum delay 2^n-1 completes at count = 2^n-1. count returns to 0 on entry to IDLE.
- Outputs are registered or decoded from registers only. grant and done are always one-hot or zero, and done is only ever set on the bit that is set in grant.

Test Plan:
1. Single request, N_REQ=4, n=16: req=0001 from before edge 1, delay0=5.
   - grant=0001 and busy=1 after edge 1; count reaches 5 after edge 6.
   - done=0001 for exactly that cycle; grant=0000 after edge 7.
2. Zero delay: req=0100, delay2=0.
   - grant=0100 and done=0100 in the same first granted cycle; released at the next edge.
3. Fairness: req=1111 held continuously, all delays=2.
   - Grant order is 0,1,2,3,0,1...
   - Each grant lasts 3 cycles, followed by 1 idle cycle; each done pulses once per grant.
4. Abort: req=0010, delay1=10; drop req1 after count=3.
   - grant=0 and count=0 at the sampling edge; no done.
   - A pending req3 is granted at the following edge.
5. Reset mid-operation: assert reset_n=0 between edges while count=4 of delay 8.
   - grant, done, busy and count go to 0 immediately.
   - After release, req=1000 and req=0001 together grant slot 0 first (rr_ptr=0).
6. Sampling/boundary, with n=8:
   - delay0=255: done at count=255 with no wrap.
   - Separately, change delay0 from 5 to 2 after the grant: done still occurs at count=5.
